alu_exec16: RTL and testbench
=============================

# alu_exec16

Sequential execute stage of the 16-bit CR16-style datapath. Takes the A and B operands from the two ALU operand muxes together with an opcode and a destination index, performs the operation, and drives the register bank's one-hot write enables and write data for exactly one cycle. Single-cycle ops complete in one cycle. MUL is an iterative 16-cycle shift-add. Status flags are held in a local PSR-style register.

## Interface
Parameters:
- MUL_CYCLES, 16, number of shift-add iterations; fixed at 16 for 16-bit operands.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Assertion immediately forces all state and outputs to reset values, independent of clk.
- start  input  1  request strobe, sampled only in IDLE.
- opcode  input  4  operation select:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 CMP, 0110 LSH, 0111 MOV, 1000 MUL
  - 1001-1111 NOP
- srcA  input  16  operand A from operand mux A.
- srcB  input  16  operand B from operand mux B.
- destSel  input  4  destination register index.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  16  write data for the register bank; holds its value between operations.
- rEnable  output  16  one-hot write enable, valid only while done is high.
- flags  output  5  {C, L, F, Z, N}.

## Operation
State machine: IDLE, MULT, DONE.
- IDLE, start=1: latch opcode, srcA, srcB, destSel.
  - MUL: go to MULT with iteration count 0.
  - All other opcodes: compute in the same edge and go to DONE.
- IDLE, start=0: stay in IDLE.
- MULT: each cycle, if multiplier bit0 is set, add the shifted multiplicand to the accumulator. Then shift the multiplier right and the multiplicand left, and increment the count.
  - After 16 iterations, go to DONE with result = low 16 bits of the product.
- DONE: done=1. Next state is always IDLE.
- start is ignored in MULT and DONE; there is no queueing.

Arithmetic and width rules (all 16-bit; no overflow beyond 16 bits is kept except in C):
- ADD: A+B.
- SUB: A-B.
- AND, OR, XOR: bitwise.
- MOV: result = B.
- LSH: the shift amount is srcB[4:0] as a signed value (-16..15).
  - Positive: logical shift left.
  - Negative: logical shift right.
  - Magnitude 16 gives 0.
- MUL: unsigned; the upper product bits are discarded.
- CMP and NOP: result register unchanged.

Write enable rules:
- rEnable = 1 << destSel during DONE.
- rEnable = 0 for CMP, for NOP, and when destSel is 13, 14 or 15 (PC, ISP, INTBASE are reserved).
- done still pulses in all of these cases.

Flag rules (flags update only on the DONE edge; bits not listed are unchanged):
- ADD: C = carry out; F = signed overflow; Z = (result==0).
- SUB: C = borrow (A<B unsigned); F = signed overflow; Z = (result==0).
- CMP: Z = (A==B); L = (A<B unsigned); N = (A<B signed).
- AND, OR, XOR, LSH, MOV, MUL: Z only.
- NOP: no flag change.

## Timing
Reset values (reset low): state IDLE, busy 0, done 0, result 0x0000, rEnable 0x0000, flags 00000, internal counters 0.

Latency:
- Non-MUL: start sampled at edge k, then done, result and rEnable are valid in the cycle after edge k (edge k+1 closes it).
- MUL: busy is high from edge k through the DONE cycle; done is high in the cycle after edge k+16 (17 cycles after acceptance).

Boundary conditions:
- Throughput: one non-MUL operation per 2 cycles. start may be re-asserted in the cycle after DONE.
- Reset asserted mid-MULT: immediate return to IDLE with reset values. No partial write occurs. Deasserting reset resumes in IDLE.
- start held high continuously: a new operation is accepted in each IDLE cycle.
- Operand inputs may change freely after acceptance; only the latched copies are used.

## Test plan
- Reset, then ADD A=0x7FFF B=0x0001 dest=3 -> done one cycle later; result 0x8000; rEnable 0x0008; C=0, F=1, Z=0.
- SUB A=0x0005 B=0x0007 dest=12 -> result 0xFFFE; rEnable 0x1000; C=1. Then CMP A=0xFFFF B=0x0001 -> rEnable 0; Z=0, L=0, N=1; result still 0xFFFE.
- MUL A=0x0123 B=0x0045 dest=0 -> busy high for 17 cycles; done at cycle 17; result 0x4E6F; rEnable 0x0001; start pulses during busy are ignored.
- LSH A=0x8001 with B=0x001F (-1) -> 0x4000; with B=0x0004 -> 0x0010; with B=0x0010 (-16) -> 0x0000; Z=1.
- MOV B=0xBEEF dest=14 -> done=1 and rEnable=0x0000. Opcode 1010 -> done=1, rEnable 0, flags unchanged.
- Start MUL, drive reset low at cycle 8 -> busy, done, rEnable, result and flags at reset values immediately. After release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_exec16.sv
// alu_exec16: sequential 16-bit execute stage.
// Single-cycle ALU ops, 16-step shift-add MUL, local PSR flags.
module alu_exec16 #(
  parameter int MUL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] srcA,
  input  logic [15:0] srcB,
  input  logic [3:0]  destSel,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [15:0] rEnable,
  output logic [4:0]  flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_LSH = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  op_q;
  logic [3:0]  dest_q;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [15:0] acc_add;
  logic [4:0]  cnt;
  logic        mul_last;

  logic [16:0] sum;
  logic [16:0] diff;
  logic [4:0]  lsh_amt;
  logic [4:0]  lsh_mag;
  logic [15:0] alu_res;
  logic [4:0]  alu_flg;
  logic        upd_z;
  logic        wr_ok;

  assign mul_last = (cnt == 5'(MUL_CYCLES - 1));
  assign acc_add  = acc + (mplier[0] ? mcand : 16'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (opcode == OP_MUL) ? MULT : DONE;
        end
      end
      MULT: begin
        if (mul_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ALU evaluated straight from the operand inputs at acceptance
  always_comb begin
    alu_res = result;
    alu_flg = flags;
    upd_z   = 1'b1;
    sum     = {1'b0, srcA} + {1'b0, srcB};
    diff    = {1'b0, srcA} - {1'b0, srcB};
    lsh_amt = srcB[4:0];
    lsh_mag = 5'd0 - lsh_amt;
    unique case (opcode)
      OP_ADD: begin
        alu_res     = sum[15:0];
        alu_flg[FC] = sum[16];
        alu_flg[FF] = (srcA[15] == srcB[15]) &&
                      (sum[15] != srcA[15]);
      end
      OP_SUB: begin
        alu_res     = diff[15:0];
        alu_flg[FC] = diff[16];
        alu_flg[FF] = (srcA[15] != srcB[15]) &&
                      (diff[15] != srcA[15]);
      end
      OP_AND: alu_res = srcA & srcB;
      OP_OR:  alu_res = srcA | srcB;
      OP_XOR: alu_res = srcA ^ srcB;
      OP_CMP: begin
        upd_z       = 1'b0;
        alu_flg[FZ] = (srcA == srcB);
        alu_flg[FL] = diff[16];
        alu_flg[FN] = $signed(srcA) < $signed(srcB);
      end
      OP_LSH: begin
        // negative amount shifts right; magnitude 16 clears the word
        alu_res = lsh_amt[4] ? (srcA >> lsh_mag)
                             : (srcA << lsh_amt[3:0]);
      end
      OP_MOV: alu_res = srcB;
      default: upd_z = 1'b0;
    endcase
    if (upd_z) begin
      alu_flg[FZ] = (alu_res == 16'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= 4'd0;
      dest_q <= 4'd0;
      mcand  <= 16'd0;
      mplier <= 16'd0;
      acc    <= 16'd0;
      cnt    <= 5'd0;
      result <= 16'd0;
      flags  <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= opcode;
            dest_q <= destSel;
            if (opcode == OP_MUL) begin
              mcand  <= srcA;
              mplier <= srcB;
              acc    <= 16'd0;
              cnt    <= 5'd0;
            end else begin
              result <= alu_res;
              flags  <= alu_flg;
            end
          end
        end
        MULT: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (mul_last) begin
            result    <= acc_add;
            flags[FZ] <= (acc_add == 16'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // PC, ISP and INTBASE (13..15) are never written from here
  assign wr_ok = (op_q <= OP_MUL) && (op_q != OP_CMP) &&
                 (dest_q < 4'd13);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rEnable = (done && wr_ok) ? (16'd1 << dest_q) : 16'd0;

endmodule

// File: tb/tb_alu_exec16.sv
// tb_alu_exec16: randomized scoreboard bench for alu_exec16.
// Driver pushes predicted completions; monitor pops on done.
module tb_alu_exec16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] srcA = 16'd0;
  logic [15:0] srcB = 16'd0;
  logic [3:0]  destSel = 4'd0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] rEnable;
  logic [4:0]  flags;

  alu_exec16 #(.MUL_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .opcode(opcode),
    .srcA(srcA),
    .srcB(srcB),
    .destSel(destSel),
    .busy(busy),
    .done(done),
    .result(result),
    .rEnable(rEnable),
    .flags(flags)
  );

  typedef struct {
    int          due;
    logic [15:0] res;
    logic [15:0] ren;
    logic [4:0]  flg;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          next_ok = 0;
  logic [15:0] m_res = 16'd0;
  logic [4:0]  m_flg = 5'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules
  task automatic model(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d,
                       output exp_t e);
    longint s;
    longint sa;
    longint sb;
    int     amt;
    logic [15:0] r;
    logic [4:0]  f;
    r  = m_res;
    f  = m_flg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin
        s = longint'(a) + longint'(b);
        r = 16'(s);
        f[4] = s > 65535;
        f[2] = (sa + sb > 32767) || (sa + sb < -32768);
        f[1] = (r == 16'd0);
      end
      4'd1: begin
        s = longint'(a) - longint'(b);
        r = 16'(s);
        f[4] = a < b;
        f[2] = (sa - sb > 32767) || (sa - sb < -32768);
        f[1] = (r == 16'd0);
      end
      4'd2: begin r = a & b; f[1] = (r == 16'd0); end
      4'd3: begin r = a | b; f[1] = (r == 16'd0); end
      4'd4: begin r = a ^ b; f[1] = (r == 16'd0); end
      4'd5: begin
        f[1] = (a == b);
        f[3] = a < b;
        f[0] = sa < sb;
      end
      4'd6: begin
        amt = int'(b[4:0]);
        if (amt > 15) amt = amt - 32;
        if (amt >= 0) r = 16'(longint'(a) << amt);
        else          r = 16'(longint'(a) >> (-amt));
        f[1] = (r == 16'd0);
      end
      4'd7: begin r = b; f[1] = (r == 16'd0); end
      4'd8: begin
        s = longint'(a) * longint'(b);
        r = 16'(s);
        f[1] = (r == 16'd0);
      end
      default: begin end
    endcase
    m_res = r;
    m_flg = f;
    e.due = 0;
    e.res = r;
    e.flg = f;
    if (op <= 4'd8 && op != 4'd5 && d < 4'd13) e.ren = 16'(32'd1 << d);
    else e.ren = 16'd0;
  endtask

  // mode 1: assert start; mode 0: start only as noise while busy
  task automatic step(input bit mode, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] d);
    exp_t e;
    bit   st;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(cyc + 1 < next_ok));
    if (mode) st = 1'b1;
    else if (cyc + 1 < next_ok) st = 1'($urandom % 2);
    else st = 1'b0;
    start = st; opcode = op; srcA = a; srcB = b; destSel = d;
    if (st && cyc + 1 >= next_ok) begin
      model(op, a, b, d, e);
      e.due = cyc + 1 + ((op == 4'd8) ? 16 : 0);
      q.push_back(e);
      next_ok = cyc + 1 + ((op == 4'd8) ? 18 : 2);
    end
  endtask

  task automatic noise();
    step(1'b0, 4'($urandom), 16'($urandom), 16'($urandom),
         4'($urandom));
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d);
    step(1'b1, op, a, b, d);
    repeat ((op == 4'd8) ? 17 : 1) noise();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done by cycle %0d (due %0d)",
                 cyc, q[0].due);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 with nothing pending");
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mon_e.due));
          chk("result", 32'(result), 32'(mon_e.res));
          chk("rEnable", 32'(rEnable), 32'(mon_e.ren));
          chk("flags", 32'(flags), 32'(mon_e.flg));
        end
      end else begin
        chk("rEnable_idle", 32'(rEnable), 32'd0);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_rEnable"}, 32'(rEnable), 32'd0);
    chk({tag, "_flags"}, 32'(flags), 32'd0);
  endtask

  initial begin
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    #1 reset = 1'b1;

    issue(4'd0, 16'h7FFF, 16'h0001, 4'd3);
    chk("tp_add_res", 32'(result), 32'h8000);
    chk("tp_add_flags", 32'(flags), 32'b00100);
    issue(4'd1, 16'h0005, 16'h0007, 4'd12);
    chk("tp_sub_res", 32'(result), 32'hFFFE);
    chk("tp_sub_c", 32'(flags[4]), 32'd1);
    issue(4'd5, 16'hFFFF, 16'h0001, 4'd2);
    chk("tp_cmp_res", 32'(result), 32'hFFFE);
    chk("tp_cmp_flags", 32'(flags), 32'b10001);
    issue(4'd8, 16'h0123, 16'h0045, 4'd0);
    chk("tp_mul_res", 32'(result), 32'h4E6F);
    issue(4'd6, 16'h8001, 16'h001F, 4'd1);
    chk("tp_lsh_m1", 32'(result), 32'h4000);
    issue(4'd6, 16'h8001, 16'h0004, 4'd1);
    chk("tp_lsh_p4", 32'(result), 32'h0010);
    issue(4'd6, 16'h8001, 16'h0010, 4'd1);
    chk("tp_lsh_m16", 32'(result), 32'h0000);
    chk("tp_lsh_z", 32'(flags[1]), 32'd1);
    issue(4'd7, 16'h1234, 16'hBEEF, 4'd14);
    chk("tp_mov_res", 32'(result), 32'hBEEF);
    issue(4'd10, 16'h0000, 16'h0000, 4'd4);
    chk("tp_nop_res", 32'(result), 32'hBEEF);

    // start held high: every IDLE cycle accepts a new operation
    repeat (40) step(1'b1, 4'($urandom_range(0, 9)), 16'($urandom),
                     16'($urandom), 4'($urandom));
    repeat (18) noise();

    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
    end

    // reset in the middle of a multiply
    issue(4'd0, 16'h0001, 16'h0001, 4'd5);
    step(1'b1, 4'd8, 16'hFFFF, 16'hFFFF, 4'd2);
    repeat (7) noise();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("mid_mul");
    q.delete();
    m_res = 16'd0;
    m_flg = 5'd0;
    next_ok = 0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    issue(4'd0, 16'h1111, 16'h2222, 4'd6);
    chk("post_reset_add", 32'(result), 32'h3333);
    repeat (3) noise();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
